// File: rtl/os_tx_scheduler.sv
// Per-lane ordered-set transmit scheduler: sequences TS1/TS2/SKP/logical-idle symbols under LTSSM control.
// Optional SKP timer and insertion enabled by defining SKP_INSERT_EN.
module os_tx_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int TS_LEN       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_n,
    input  logic [1:0]  os_sel,
    input  logic [7:0]  link_num,
    input  logic [7:0]  lane_num,
    input  logic [7:0]  n_fts,
    input  logic [7:0]  rate_id,
    input  logic [7:0]  train_ctl,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        txvalid,
    output logic        os_start,
    output logic        skp_active,
    output logic [15:0] ts1_sent_ctr,
    output logic [15:0] ts2_sent_ctr
);
    localparam logic [3:0] TS_LAST  = 4'(TS_LEN - 1);
    localparam logic [3:0] SKP_LAST = 4'd3;
    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] SKP_SYM  = 8'h1C;
    localparam logic [7:0] PAD      = 8'hF7;
    localparam logic [7:0] TS1_ID   = 8'h4A;
    localparam logic [7:0] TS2_ID   = 8'h45;

    typedef enum logic [2:0] {ST_OFF, ST_LIDLE, ST_TS1, ST_TS2, ST_SKP} state_t;

    state_t     state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic       boundary, skp_due;
    logic [7:0] link_q, lane_q, nfts_q, rate_q, ctl_q;
    logic [7:0] data_nxt;
    logic       k_nxt, start_nxt;

`ifdef SKP_INSERT_EN
    localparam int TMR_W = $clog2(SKP_INTERVAL);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SKP_INTERVAL - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [TMR_W-1:0] skp_tmr;
    logic             skp_pend, skp_wrap;

    // The timer counts symbol times actually driven, so the first cycle out of OFF is not counted.
    assign skp_wrap = (state != ST_OFF) && (skp_tmr == TMR_LAST);
    assign skp_due  = skp_pend | skp_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skp_tmr    <= '0;
            skp_pend   <= 1'b0;
            skp_active <= 1'b0;
        end else if (en_n) begin
            skp_tmr    <= '0;
            skp_pend   <= 1'b0;
            skp_active <= 1'b0;
        end else begin
            if (state != ST_OFF)
                skp_tmr <= skp_wrap ? '0 : skp_tmr + TMR_ONE;
            if (state_nxt == ST_SKP && idx_nxt == 4'd0)
                skp_pend <= 1'b0;
            else if (skp_wrap)
                skp_pend <= 1'b1;
            skp_active <= (state_nxt == ST_SKP);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(SKP_INTERVAL);
    assign skp_due    = 1'b0;
    assign skp_active = 1'b0;
`endif

    always_comb begin
        boundary = (state == ST_OFF) || (state == ST_LIDLE) ||
                   ((state == ST_TS1 || state == ST_TS2) && idx == TS_LAST) ||
                   ((state == ST_SKP) && idx == SKP_LAST);
        state_nxt = state;
        idx_nxt   = idx + 4'd1;
        if (en_n) begin
            state_nxt = ST_OFF;
            idx_nxt   = 4'd0;
        end else if (boundary) begin
            idx_nxt = 4'd0;
            if (skp_due)             state_nxt = ST_SKP;
            else if (os_sel == 2'b01) state_nxt = ST_TS1;
            else if (os_sel == 2'b10) state_nxt = ST_TS2;
            else                     state_nxt = ST_LIDLE;
        end
    end

    // Symbol for the next cycle; TS fields come from the copy latched at the set's COM.
    always_comb begin
        data_nxt  = 8'h00;
        k_nxt     = 1'b0;
        start_nxt = 1'b0;
        case (state_nxt)
            ST_SKP: begin
                data_nxt  = (idx_nxt == 4'd0) ? COM : SKP_SYM;
                k_nxt     = 1'b1;
                start_nxt = (idx_nxt == 4'd0);
            end
            ST_TS1, ST_TS2: begin
                case (idx_nxt)
                    4'd0: begin
                        data_nxt  = COM;
                        k_nxt     = 1'b1;
                        start_nxt = 1'b1;
                    end
                    4'd1: begin
                        data_nxt = link_q;
                        k_nxt    = (link_q == PAD);
                    end
                    4'd2: begin
                        data_nxt = lane_q;
                        k_nxt    = (lane_q == PAD);
                    end
                    4'd3:    data_nxt = nfts_q;
                    4'd4:    data_nxt = rate_q;
                    4'd5:    data_nxt = ctl_q;
                    default: data_nxt = (state_nxt == ST_TS1) ? TS1_ID : TS2_ID;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_OFF;
            idx          <= 4'd0;
            txdata       <= 8'h00;
            txdatak      <= 1'b0;
            txvalid      <= 1'b0;
            os_start     <= 1'b0;
            ts1_sent_ctr <= 16'h0000;
            ts2_sent_ctr <= 16'h0000;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            txdata   <= data_nxt;
            txdatak  <= k_nxt;
            txvalid  <= (state_nxt != ST_OFF);
            os_start <= start_nxt;
            if (state_nxt == ST_TS1 && idx_nxt == TS_LAST && ts1_sent_ctr != 16'hFFFF)
                ts1_sent_ctr <= ts1_sent_ctr + 16'd1;
            if (state_nxt == ST_TS2 && idx_nxt == TS_LAST && ts2_sent_ctr != 16'hFFFF)
                ts2_sent_ctr <= ts2_sent_ctr + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!en_n && boundary) begin
            link_q <= link_num;
            lane_q <= lane_num;
            nfts_q <= n_fts;
            rate_q <= rate_id;
            ctl_q  <= train_ctl;
        end
    end

endmodule

// File: doc/os_tx_scheduler.md
Name: os_tx_scheduler

Overview:
Per-lane ordered-set transmit scheduler for the PHY. It sequences TS1, TS2, SKP and logical-idle symbols onto one lane's 8-bit symbol/K datapath under LTSSM control. It also arbitrates between LTSSM-requested training sets and periodic SKP insertion. One instance per lane, driven by the lane's LTSSM; its symbol output feeds the lane encoder and the MAC-side driver interface.

Parameters:
SKP_INTERVAL, 1180, symbol times between SKP-ordered-set requests (min 32)
TS_LEN, 16, symbols per TS1/TS2 ordered set (fixed by protocol; not for override)

Ports:
clk  input  1  PHY clock (pclk domain)
reset_n  input  1  asynchronous active-low reset
en_n  input  1  transmitter enable, active low (high = electrical idle)
os_sel  input  2  requested stream: 00 logical idle, 01 TS1, 10 TS2, 11 treated as 00
link_num  input  8  TS symbol 1
lane_num  input  8  TS symbol 2
n_fts  input  8  TS symbol 3
rate_id  input  8  TS symbol 4
train_ctl  input  8  TS symbol 5
txdata  output  8  symbol out
txdatak  output  1  K-character flag for txdata
txvalid  output  1  txdata/txdatak carry a symbol this cycle
os_start  output  1  pulses with the COM symbol of every TS or SKP set
skp_active  output  1  high while SKP set symbols are on txdata
ts1_sent_ctr  output  16  completed TS1 sets, saturating
ts2_sent_ctr  output  16  completed TS2 sets, saturating

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset reset_n.
- Reset values: all outputs 0; state OFF; symbol index 0; SKP timer 0; SKP pending 0.
- All outputs are registered. If en_n is sampled low in cycle N, the first symbol appears in cycle N+1.
- OFF: entered on reset or whenever en_n=1, including mid-set. An abort takes effect on the next edge.
  - In OFF: txvalid=0, txdata=0, txdatak=0; SKP timer and pending cleared.
  - Counters hold. A partial set is not counted.
- Set boundary: the cycle after the last symbol of a set or an idle symbol, or the first cycle out of OFF. At each boundary, in priority order:
  - SKP pending → SKP.
  - else os_sel=01 → TS1.
  - else os_sel=10 → TS2.
  - else → LIDLE.
- os_sel, link_num, lane_num, n_fts, rate_id and train_ctl are latched at the boundary and held for the whole set. Changes mid-set take effect at the next boundary.
- TS (TS1 or TS2), symbol index 0..15:
  - Sym 0: 8'hBC, k=1 (COM); os_start=1.
  - Sym 1-5: latched link_num, lane_num, n_fts, rate_id, train_ctl. For sym 1 and 2, k=1 iff the value is 8'hF7 (PAD); for sym 3-5, k=0.
  - Sym 6-15: 8'h4A (TS1 identifier) or 8'h45 (TS2 identifier), k=0.
  - The counter increments in the cycle sym 15 is driven, saturating at 16'hFFFF.
- SKP, 4 symbols: 8'hBC k=1 with os_start=1, then 3× 8'h1C k=1. skp_active=1 for all 4 cycles. Pending is cleared when the COM is driven.
- LIDLE: one symbol, 8'h00, k=0. Every LIDLE cycle is a boundary.
- txvalid=1 in every non-OFF state.
- SKP timer:
  - Counts each non-OFF cycle from 0 to SKP_INTERVAL-1, then wraps.
  - Sets pending on wrap. A wrap while pending is already set is absorbed; SKP sets never queue beyond one.
  - SKP is never inserted inside a TS set.
- Simultaneous events:
  - en_n rising in the cycle sym 15 is driven: sym 15 completes and is counted, then OFF.
  - Wrap in the same cycle as a boundary: the SKP wins that boundary.

Optional Feature:
SKP_INSERT_EN — when defined, SKP timer and insertion behave as above. When undefined, no timer logic exists, skp_active is tied 0, and boundaries select only TS1/TS2/LIDLE.

Test Plan:
- Reset, en_n=1, os_sel=01 for 50 cycles → txvalid=0, txdata=0, both counters 0.
- en_n low with os_sel=01, link_num=F7, lane_num=03, n_fts=FF, rate_id=02, train_ctl=00 → next cycle BC/k1; then F7/k1, 03/k0, FF/k0, 02/k0, 00/k0, 10×4A/k0; ts1_sent_ctr=1 after 16 cycles; repeats back-to-back.
- Switch os_sel 01→10 at TS1 sym 7 → TS1 completes with 4A symbols; next set has 45 identifiers; ts2_sent_ctr increments 16 cycles later.
- SKP_INSERT_EN, SKP_INTERVAL=40, os_sel=01 continuous → SKP (BC,1C,1C,1C, skp_active=1) only at the first boundary after cycle 40; never between TS sym 0-15; ≤1 SKP per wrap.
- en_n raised at TS2 sym 9 → next cycle txvalid=0; ts2_sent_ctr unchanged; on re-enable, first symbol is a fresh COM.
- Preload both counters to FFFE via force, run 3 TS1 and 3 TS2 sets → both read FFFF and hold.
